// File: rtl/smem_dma_if.sv
// DMA-side bus between the two requesters and the SMEM-aware arbiter.
interface smem_dma_if;
    logic [15:0] pc;
    logic [1:0]  req;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [1:0]  grant;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic [1:0]  starve;

    modport master (
        output pc, req, addr0, addr1,
        input  grant, dma_en, dma_addr, starve
    );

    modport slave (
        input  pc, req, addr0, addr1,
        output grant, dma_en, dma_addr, starve
    );
endinterface

// File: rtl/smem_dma_arbiter.sv
// Round-robin arbiter for two DMA masters that withholds grants while pc is inside SMEM.
// Define SMEM_EXIT_GUARD_EN to hold grants off for EXIT_GUARD cycles after leaving SMEM.
module smem_dma_arbiter #(
    parameter logic [15:0] SMEM_BASE  = 16'hA000,
    parameter logic [15:0] SMEM_SIZE  = 16'h4000,
    parameter logic [3:0]  EXIT_GUARD = 4'd2,
    parameter logic [7:0]  BURST_MAX  = 8'd16,
    parameter logic [7:0]  MAX_WAIT   = 8'd64
) (
    input logic       clk,
    input logic       reset,
    smem_dma_if.slave bus
);
    localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BLOCKED = 2'd2
`ifdef SMEM_EXIT_GUARD_EN
        , S_GUARD = 2'd3
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            rr_q, rr_d;
    logic [7:0]      burst_q, burst_d;
    logic [1:0][7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]      starve_q, starve_d;
    logic [1:0]      grant_rise;
    logic            in_smem;
    logic            owner;
    logic            winner;
`ifdef SMEM_EXIT_GUARD_EN
    logic [3:0]      guard_q, guard_d;
`else
    // EXIT_GUARD has no effect without the guard state.
    logic            unused_exit_guard;
    assign unused_exit_guard = ^EXIT_GUARD;
`endif

    assign in_smem = (bus.pc >= SMEM_BASE) && (bus.pc <= SMEM_LAST);
    assign owner   = grant_q[1];
    assign winner  = bus.req[rr_q] ? rr_q : ~rr_q;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        burst_d = burst_q;
`ifdef SMEM_EXIT_GUARD_EN
        guard_d = guard_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_smem) begin
                    state_d = S_BLOCKED;
                end else if (|bus.req) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    burst_d = 8'd0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // SMEM entry wins over release and leaves the round-robin pointer alone.
                if (in_smem) begin
                    grant_d = 2'b00;
                    state_d = S_BLOCKED;
                end else if (!bus.req[owner] || burst_q == BURST_MAX - 8'd1) begin
                    grant_d = 2'b00;
                    rr_d    = ~owner;
                    state_d = S_IDLE;
                end else begin
                    burst_d = burst_q + 8'd1;
                end
            end
            S_BLOCKED: begin
                if (!in_smem) begin
`ifdef SMEM_EXIT_GUARD_EN
                    guard_d = 4'd0;
                    state_d = S_GUARD;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef SMEM_EXIT_GUARD_EN
            S_GUARD: begin
                if (in_smem) begin
                    guard_d = 4'd0;
                    state_d = S_BLOCKED;
                end else if ({1'b0, guard_q} + 5'd1 >= {1'b0, EXIT_GUARD}) begin
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
`endif
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant_rise = grant_d & ~grant_q;

    // Starvation is sticky across request drops; only a fresh grant clears it.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        starve_d   = starve_q;
        for (int i = 0; i < 2; i++) begin
            if (!bus.req[i] || grant_rise[i]) begin
                wait_cnt_d[i] = 8'd0;
            end else if (!grant_q[i] && wait_cnt_q[i] != MAX_WAIT) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 8'd1;
            end
            if (grant_rise[i]) begin
                starve_d[i] = 1'b0;
            end else if (wait_cnt_d[i] == MAX_WAIT) begin
                starve_d[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            rr_q       <= 1'b0;
            burst_q    <= 8'd0;
            wait_cnt_q <= '0;
            starve_q   <= 2'b00;
`ifdef SMEM_EXIT_GUARD_EN
            guard_q    <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            burst_q    <= burst_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
`ifdef SMEM_EXIT_GUARD_EN
            guard_q    <= guard_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.dma_en   = (|grant_q) & ~in_smem;
    assign bus.dma_addr = grant_q[0] ? bus.addr0 : (grant_q[1] ? bus.addr1 : 16'h0000);
    assign bus.starve   = starve_q;
endmodule

// File: tb/tb_smem_dma_arbiter.sv
// Self-checking bench: directed vector table, hand-written SMEM/starvation/reset sequences,
// then random stimulus against a transaction-level reference model.
module tb_smem_dma_arbiter;
    localparam logic [15:0] A0 = 16'h1234;
    localparam logic [15:0] A1 = 16'h5678;
    localparam int BURST = 16;
    localparam int MAXA  = 64;
    localparam int MAXB  = 8;
`ifdef SMEM_EXIT_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    smem_dma_if bus_a ();
    smem_dma_if bus_b ();
    assign bus_b.pc    = bus_a.pc;
    assign bus_b.req   = bus_a.req;
    assign bus_b.addr0 = bus_a.addr0;
    assign bus_b.addr1 = bus_a.addr1;

    smem_dma_arbiter dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    smem_dma_arbiter #(.MAX_WAIT(8'd8)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner index, cycles held, edges to sit out before a grant is allowed.
    int         m_owner = -1;
    int         m_held = 0;
    int         m_hold_off = 0;
    int         m_pref = 0;
    int         m_wait [2] = '{0, 0};
    logic [1:0] m_sa = 2'b00;
    logic [1:0] m_sb = 2'b00;

    always @(posedge clk) begin : model
        logic ins;
        int   nxt;
        ins = (bus_a.pc >= 16'hA000) && (bus_a.pc <= 16'hDFFE);
        if (reset) begin
            m_owner = -1; m_held = 0; m_hold_off = 0; m_pref = 0;
            m_wait[0] = 0; m_wait[1] = 0; m_sa = 2'b00; m_sb = 2'b00;
        end else begin
            nxt = m_owner;
            if (m_owner >= 0) begin
                if (ins) begin
                    nxt = -1; m_hold_off = 1 + G;
                end else if (!bus_a.req[m_owner] || m_held == BURST - 1) begin
                    nxt = -1; m_pref = 1 - m_owner; m_hold_off = 0;
                end else begin
                    m_held++;
                end
            end else if (ins) begin
                m_hold_off = 1 + G;
            end else if (m_hold_off > 0) begin
                m_hold_off--;
            end else if (bus_a.req != 2'b00) begin
                nxt = bus_a.req[m_pref] ? m_pref : 1 - m_pref;
                m_held = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!bus_a.req[i]) begin
                    m_wait[i] = 0;
                end else if (nxt == i && m_owner != i) begin
                    m_wait[i] = 0; m_sa[i] = 1'b0; m_sb[i] = 1'b0;
                end else if (m_owner != i) begin
                    m_wait[i]++;
                end
                if (m_wait[i] >= MAXA) m_sa[i] = 1'b1;
                if (m_wait[i] >= MAXB) m_sb[i] = 1'b1;
            end
            m_owner = nxt;
        end
    end

    function automatic logic [1:0] m_grant();
        return (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    endfunction

    task automatic compare_model();
        logic        ins;
        logic [15:0] exp_addr;
        ins = (bus_a.pc >= 16'hA000) && (bus_a.pc <= 16'hDFFE);
        exp_addr = (m_owner == 0) ? bus_a.addr0 : ((m_owner == 1) ? bus_a.addr1 : 16'h0000);
        check("rnd grant_a", 16'(bus_a.grant), 16'(m_grant()));
        check("rnd dma_en_a", 16'(bus_a.dma_en), 16'((|m_grant()) & ~ins));
        check("rnd dma_addr_a", bus_a.dma_addr, exp_addr);
        check("rnd starve_a", 16'(bus_a.starve), 16'(m_sa));
        check("rnd grant_b", 16'(bus_b.grant), 16'(m_grant()));
        check("rnd starve_b", 16'(bus_b.starve), 16'(m_sb));
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  req;
        logic [1:0]  grant;
        logic        en;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{16'h4000, 2'b00, 2'b00, 1'b0, 16'h0000};
        vecs[1]  = '{16'h4000, 2'b01, 2'b01, 1'b1, A0};
        vecs[2]  = '{16'h4000, 2'b01, 2'b01, 1'b1, A0};
        vecs[3]  = '{16'h4000, 2'b00, 2'b00, 1'b0, 16'h0000};
        vecs[4]  = '{16'h9FFE, 2'b10, 2'b10, 1'b1, A1};
        vecs[5]  = '{16'h9FFE, 2'b00, 2'b00, 1'b0, 16'h0000};
        vecs[6]  = '{16'h4000, 2'b11, 2'b01, 1'b1, A0};
        vecs[7]  = '{16'h4000, 2'b10, 2'b00, 1'b0, 16'h0000};
        vecs[8]  = '{16'h4000, 2'b11, 2'b10, 1'b1, A1};
        vecs[9]  = '{16'h4000, 2'b01, 2'b00, 1'b0, 16'h0000};
        vecs[10] = '{16'h4000, 2'b01, 2'b01, 1'b1, A0};
        vecs[11] = '{16'hDFFE, 2'b01, 2'b00, 1'b0, 16'h0000};
        vecs[12] = '{16'hDFFE, 2'b01, 2'b00, 1'b0, 16'h0000};

        reset = 1'b1;
        bus_a.pc = 16'h4000; bus_a.req = 2'b00; bus_a.addr0 = A0; bus_a.addr1 = A1;
        tick(); tick();
        check("reset grant", 16'(bus_a.grant), 16'h0);
        check("reset dma_en", 16'(bus_a.dma_en), 16'h0);
        check("reset dma_addr", bus_a.dma_addr, 16'h0);
        check("reset starve", 16'(bus_a.starve), 16'h0);
        reset = 1'b0;

        // Directed table: single requests, release, round-robin choice, boundary pcs.
        for (int k = 0; k < 13; k++) begin
            bus_a.pc = vecs[k].pc; bus_a.req = vecs[k].req;
            tick();
            check($sformatf("vec%0d grant", k), 16'(bus_a.grant), 16'(vecs[k].grant));
            check($sformatf("vec%0d dma_en", k), 16'(bus_a.dma_en), 16'(vecs[k].en));
            check($sformatf("vec%0d dma_addr", k), bus_a.dma_addr, vecs[k].addr);
        end

        // Exit at 16'hE000: no grant until the exit (and guard) edges have passed.
        bus_a.pc = 16'hE000;
        for (int k = 0; k <= G; k++) begin
            tick();
            check("exit wait grant", 16'(bus_a.grant), 16'h0);
        end
        tick();
        check("exit resume grant", 16'(bus_a.grant), 16'h1);
        check("exit resume dma_en", 16'(bus_a.dma_en), 16'h1);

        // SMEM preemption of requester 1.
        bus_a.req = 2'b00; tick();
        check("drop grant", 16'(bus_a.grant), 16'h0);
        bus_a.req = 2'b10; tick(); tick();
        check("pre grant r1", 16'(bus_a.grant), 16'h2);
        bus_a.pc = 16'hA000; #1;
        check("entry same-cycle dma_en", 16'(bus_a.dma_en), 16'h0);
        check("entry same-cycle grant", 16'(bus_a.grant), 16'h2);
        tick();
        check("entry next-edge grant", 16'(bus_a.grant), 16'h0);
        bus_a.pc = 16'hDFFE;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("last word blocked", 16'(bus_a.grant), 16'h0);
        end
        bus_a.pc = 16'hE000;
        for (int k = 0; k <= G; k++) begin
            tick();
            check("exit2 wait grant", 16'(bus_a.grant), 16'h0);
        end
        tick();
        check("exit2 resume grant", 16'(bus_a.grant), 16'h2);
        check("exit2 dma_addr", bus_a.dma_addr, A1);

        // Continuous dual request: 16-cycle bursts alternating, one idle cycle between.
        bus_a.req = 2'b00; tick(); tick();
        bus_a.req = 2'b11;
        for (int c = 0; c < 68; c++) begin
            logic [1:0] exp_g;
            tick();
            if ((c % 17) == 16) exp_g = 2'b00;
            else exp_g = (((c / 17) % 2) == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr c%0d grant", c), 16'(bus_a.grant), 16'(exp_g));
            check("rr starve_a", 16'(bus_a.starve), 16'h0);
        end

        // Starvation while held in SMEM (dut_b uses MAX_WAIT=8).
        reset = 1'b1; bus_a.req = 2'b00; tick(); reset = 1'b0;
        bus_a.pc = 16'hA000; bus_a.req = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("starve k%0d", k), 16'(bus_b.starve), (k >= 8) ? 16'h1 : 16'h0);
            check("starve grant", 16'(bus_b.grant), 16'h0);
        end
        check("starve_a default", 16'(bus_a.starve), 16'h0);
        bus_a.pc = 16'h4000;
        for (int k = 0; k <= G; k++) begin
            tick();
            check("starve held", 16'(bus_b.starve), 16'h1);
        end
        tick();
        check("starve grant after exit", 16'(bus_b.grant), 16'h1);
        check("starve cleared on grant", 16'(bus_b.starve), 16'h0);

        // Reset in the middle of a grant with both requesters pending.
        bus_a.req = 2'b10; tick(); tick();
        check("pre-reset grant r1", 16'(bus_b.grant), 16'h2);
        bus_a.req = 2'b11;
        for (int k = 0; k < 9; k++) tick();
        check("pre-reset starve", 16'(bus_b.starve), 16'h1);
        reset = 1'b1; tick();
        check("mid reset grant", 16'(bus_b.grant), 16'h0);
        check("mid reset starve", 16'(bus_b.starve), 16'h0);
        check("mid reset dma_addr", bus_b.dma_addr, 16'h0);
        check("mid reset dma_en", 16'(bus_b.dma_en), 16'h0);
        reset = 1'b0; tick();
        check("post reset grant r0", 16'(bus_b.grant), 16'h1);
        check("post reset dma_addr", bus_b.dma_addr, A0);

        // Random traffic against the reference model.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 7))
                    0: bus_a.pc = 16'h9FFE;
                    1: bus_a.pc = 16'hA000;
                    2: bus_a.pc = 16'hDFFE;
                    3: bus_a.pc = 16'hE000;
                    4: bus_a.pc = 16'($urandom_range(16'hA000, 16'hDFFF));
                    5: bus_a.pc = 16'hDFFF;
                    default: bus_a.pc = 16'($urandom_range(0, 16'h9FFF));
                endcase
            end
            if ($urandom_range(0, 9) == 0) bus_a.req[0] = ~bus_a.req[0];
            if ($urandom_range(0, 9) == 0) bus_a.req[1] = ~bus_a.req[1];
            bus_a.addr0 = 16'($urandom);
            bus_a.addr1 = 16'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            tick();
            compare_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
